merge2_encoder: RTL and testbench

- Clocked 2-to-1 packet merge. It takes two 9-bit flit streams, arbitrates between them, and drives one output stream plus a side-band select bit that records the source input.
- It is the encoder counterpart of the 1-of-2 packet decoder: it rebuilds a single link from an Out0/Out1 split plus S.
- It sits at the synchronous edge of the NoC, ahead of the link's full_buffer stage.
- Arbitration is round-robin and wormhole: once a packet is granted, the grant holds until that packet's tail flit is transferred.

---
 rtl/merge2_encoder.sv | 143 ++++++++++++++
 tb/tb_merge2_encoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge2_encoder.sv
// -----------------------------------------------------------------------------
// merge2_encoder
//   Clocked 2-to-1 wormhole packet merge. Two W-bit flit streams are
//   arbitrated round-robin, packet by packet; once a packet is granted the
//   grant holds until its tail flit (bit TAIL_BIT = 1) has transferred.
//   Accepted flits go through a 2-entry output FIFO of {sel, data}, so the
//   output side is fully registered with 1-cycle latency.
//
// Ports
//   CLK        clock, rising edge
//   _RESET     asynchronous active-low reset
//   in0_data   flit from source 0        in0_valid / in0_ready  handshake
//   in1_data   flit from source 1        in1_valid / in1_ready  handshake
//   out_data   merged flit (FIFO head)
//   out_sel    source index of out_data (the S channel)
//   out_valid  head entry present         out_ready  downstream accepts head
// -----------------------------------------------------------------------------
module merge2_encoder #(
    parameter int W        = 9,
    parameter int TAIL_BIT = W - 1,
    parameter int DEPTH    = 2
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_sel,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    state_t     state;
    logic       last;               // source that completed the most recent packet
    logic [1:0] count;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [W:0] mem [DEPTH];        // {sel, data}

    logic         gnt_valid;
    logic         gnt_idx;
    logic         room;
    logic         push;
    logic         pop;
    logic [W-1:0] push_data;

    // Grant selection. In IDLE the grant follows the valids combinationally;
    // in a LOCK state it is pinned to the owning source until the tail.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = ~last;
                end else if (in0_valid) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = 1'b0;
                end else if (in1_valid) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = 1'b1;
                end
            end
            LOCK0: begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b0;
            end
            LOCK1: begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b1;
            end
            default: ;
        endcase
    end

    // No same-cycle bypass: a full FIFO refuses input even when popping.
    assign room = (count != FULL);

    // Readys are gated by _RESET so they drop the instant reset asserts,
    // without waiting for the state registers to settle.
    assign in0_ready = _RESET && gnt_valid && !gnt_idx && room;
    assign in1_ready = _RESET && gnt_valid &&  gnt_idx && room;

    assign push_data = gnt_idx ? in1_data : in0_data;
    assign push      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    assign pop       = (count != 2'd0) && out_ready;

    assign out_valid          = (count != 2'd0);
    assign {out_sel, out_data} = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state  <= IDLE;
            last   <= 1'b1;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            // NOTE: the FIFO storage is reset because its head drives out_data
            // directly and must read as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {gnt_idx, push_data};
                wr_ptr      <= ~wr_ptr;
                if (push_data[TAIL_BIT]) begin
                    state <= IDLE;
                    last  <= gnt_idx;
                end else begin
                    state <= gnt_idx ? LOCK1 : LOCK0;
                end
            end

            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_merge2_encoder.sv
// -----------------------------------------------------------------------------
// tb_merge2_encoder
//   Directed bench for merge2_encoder. Inputs change 1 time unit after the
//   rising edge; outputs and readys are sampled on the falling edge. A monitor
//   logs every output pop as {sel, data} for per-test ordering checks.
// -----------------------------------------------------------------------------
module tb_merge2_encoder;

    logic       CLK = 1'b0;
    logic       _RESET;
    logic [8:0] in0_data, in1_data, out_data;
    logic       in0_valid, in1_valid, in0_ready, in1_ready;
    logic       out_sel, out_valid, out_ready;

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0] got_q [$];

    always #5 CLK = ~CLK;

    merge2_encoder dut (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // A pop happens on the next rising edge whenever this condition holds.
    always @(negedge CLK) begin
        if (_RESET && out_valid && out_ready) got_q.push_back({out_sel, out_data});
    end

    // A held valid must keep its data stable until accepted.
    logic [8:0] prev0, prev1;
    logic       pend0, pend1;
    always @(posedge CLK) begin
        if (_RESET && pend0 && in0_valid) assert (in0_data == prev0) else $error("in0 data changed while pending");
        if (_RESET && pend1 && in1_valid) assert (in1_data == prev1) else $error("in1 data changed while pending");
        pend0 <= in0_valid && !in0_ready;
        pend1 <= in1_valid && !in1_ready;
        prev0 <= in0_data;
        prev1 <= in1_data;
    end

    task automatic set_in(input int src, input logic v, input logic [8:0] d);
        if (src == 0) begin in0_valid = v; in0_data = d; end
        else          begin in1_valid = v; in1_data = d; end
    endtask

    // Leaves the bench 1 unit after a rising edge with reset released.
    task automatic do_reset();
        _RESET = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_data = '0; in1_data = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1 _RESET = 1'b1;
        got_q.delete();
    endtask

    // Offers n flits in order on one source, holding each until accepted.
    task automatic send(input int src, input logic [8:0] flits [4], input int n);
        int  waited;
        bit  done;
        for (int i = 0; i < n; i++) begin
            set_in(src, 1'b1, flits[i]);
            done   = 1'b0;
            waited = 0;
            while (!done) begin
                @(negedge CLK);
                if ((src == 0) ? in0_ready : in1_ready) done = 1'b1;
                @(posedge CLK);
                #1;
                waited++;
                if (!done && waited > 50) begin
                    vectors++; miscompares++;
                    $display("FAIL send_timeout src%0d flit %h: no ready within 50 cycles, required ready", src, flits[i]);
                    done = 1'b1;
                end
            end
        end
        set_in(src, 1'b0, '0);
    endtask

    task automatic drain_and_compare(input string name, input logic [9:0] exp [8], input int n);
        repeat (5) @(posedge CLK);
        #1;
        vectors++;
        if (got_q.size() !== n) begin
            miscompares++;
            $display("FAIL %s_count: got %0d pops, required %0d", name, got_q.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL %s_pop%0d: got {sel,data}=%h, required %h", name, i,
                         (i < got_q.size()) ? got_q[i] : 10'h3ff, exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        _RESET = 1'b0;
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_data = 9'h0AA; in1_data = 9'h055;
        out_ready = 1'b1;
        #3;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        vectors++; if (out_data !== 9'h000) begin miscompares++; $display("FAIL reset_out_data: got %h required 000", out_data); end
        vectors++; if (out_sel !== 1'b0) begin miscompares++; $display("FAIL reset_out_sel: got %b required 0", out_sel); end
        vectors++; if (in0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in0_ready: got %b required 0", in0_ready); end
        vectors++; if (in1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in1_ready: got %b required 0", in1_ready); end
    endtask

    task automatic test_single_flit();
        do_reset();
        out_ready = 1'b1;
        set_in(0, 1'b1, 9'h1AB);
        @(negedge CLK);
        vectors++; if (in0_ready !== 1'b1) begin miscompares++; $display("FAIL single_in0_ready: got %b required 1", in0_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pre_valid: got %b required 0", out_valid); end
        @(posedge CLK); #1;
        set_in(0, 1'b0, '0);
        @(negedge CLK);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid: got %b required 1", out_valid); end
        vectors++; if (out_data !== 9'h1AB) begin miscompares++; $display("FAIL single_out_data: got %h required 1ab", out_data); end
        vectors++; if (out_sel !== 1'b0) begin miscompares++; $display("FAIL single_out_sel: got %b required 0", out_sel); end
        @(posedge CLK); #1;
        @(negedge CLK);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_after_pop_valid: got %b required 0", out_valid); end
        @(posedge CLK); #1;
    endtask

    task automatic test_wormhole();
        logic [8:0] p0 [4] = '{9'h001, 9'h002, 9'h103, 9'h000};
        logic [8:0] p1 [4] = '{9'h011, 9'h012, 9'h113, 9'h000};
        logic [9:0] exp [8] = '{10'h001, 10'h002, 10'h103, 10'h211, 10'h212, 10'h313, 10'h000, 10'h000};
        do_reset();
        out_ready = 1'b1;
        fork
            send(0, p0, 3);
            send(1, p1, 3);
        join
        drain_and_compare("wormhole", exp, 6);
    endtask

    task automatic test_fairness();
        logic [8:0] p0 [4] = '{9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3};
        logic [8:0] p1 [4] = '{9'h1B0, 9'h1B1, 9'h1B2, 9'h1B3};
        // The 7th grant (sel 0) shows last ended at 1 after the first six.
        logic [9:0] exp [8] = '{10'h1A0, 10'h3B0, 10'h1A1, 10'h3B1,
                                10'h1A2, 10'h3B2, 10'h1A3, 10'h3B3};
        do_reset();
        out_ready = 1'b1;
        fork
            send(0, p0, 4);
            send(1, p1, 4);
        join
        drain_and_compare("fairness", exp, 8);
    endtask

    task automatic test_backpressure();
        logic [9:0] exp [8] = '{10'h205, 10'h206, 10'h207, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
        do_reset();
        out_ready = 1'b0;
        set_in(1, 1'b1, 9'h005);
        @(negedge CLK);
        vectors++; if (in1_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_1st: got %b required 1", in1_ready); end
        @(posedge CLK); #1;
        set_in(1, 1'b1, 9'h006);
        @(negedge CLK);
        vectors++; if (in1_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_2nd: got %b required 1", in1_ready); end
        @(posedge CLK); #1;
        set_in(1, 1'b1, 9'h007);
        @(negedge CLK);
        vectors++; if (in1_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_3rd: got %b required 0", in1_ready); end
        vectors++; if (out_data !== 9'h005) begin miscompares++; $display("FAIL bp_head: got %h required 005", out_data); end
        @(posedge CLK); #1;
        out_ready = 1'b1;
        @(negedge CLK);
        vectors++; if (in1_ready !== 1'b0) begin miscompares++; $display("FAIL bp_no_bypass: got %b required 0", in1_ready); end
        @(posedge CLK); #1;
        @(negedge CLK);
        vectors++; if (in1_ready !== 1'b1) begin miscompares++; $display("FAIL bp_recover: got %b required 1", in1_ready); end
        @(posedge CLK); #1;
        set_in(1, 1'b0, '0);
        drain_and_compare("backpressure", exp, 3);
    endtask

    task automatic test_lock_hold();
        logic [9:0] exp [8] = '{10'h021, 10'h122, 10'h331, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
        do_reset();
        out_ready = 1'b1;
        set_in(0, 1'b1, 9'h021);
        set_in(1, 1'b1, 9'h131);
        @(negedge CLK);
        vectors++; if (in0_ready !== 1'b1) begin miscompares++; $display("FAIL lock_in0_first: got %b required 1", in0_ready); end
        vectors++; if (in1_ready !== 1'b0) begin miscompares++; $display("FAIL lock_in1_first: got %b required 0", in1_ready); end
        @(posedge CLK); #1;
        set_in(0, 1'b0, '0);
        @(negedge CLK);
        vectors++; if (in1_ready !== 1'b0) begin miscompares++; $display("FAIL lock_in1_held: got %b required 0", in1_ready); end
        @(posedge CLK); #1;
        set_in(0, 1'b1, 9'h122);
        @(negedge CLK);
        vectors++; if (in1_ready !== 1'b0) begin miscompares++; $display("FAIL lock_in1_at_tail: got %b required 0", in1_ready); end
        @(posedge CLK); #1;
        set_in(0, 1'b0, '0);
        @(negedge CLK);
        vectors++; if (in1_ready !== 1'b1) begin miscompares++; $display("FAIL lock_in1_granted: got %b required 1", in1_ready); end
        @(posedge CLK); #1;
        set_in(1, 1'b0, '0);
        drain_and_compare("lock_hold", exp, 3);
    endtask

    task automatic test_async_reset();
        logic [9:0] exp [8] = '{10'h150, 10'h243, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
        do_reset();
        out_ready = 1'b0;
        set_in(1, 1'b1, 9'h041);
        @(posedge CLK); #1;
        set_in(1, 1'b1, 9'h042);
        @(posedge CLK); #1;
        set_in(1, 1'b1, 9'h043);
        set_in(0, 1'b1, 9'h150);
        @(negedge CLK);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre_valid: got %b required 1", out_valid); end
        vectors++; if (in1_ready !== 1'b0) begin miscompares++; $display("FAIL arst_pre_full: got %b required 0", in1_ready); end
        @(posedge CLK); #2;
        _RESET = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_out_valid: got %b required 0", out_valid); end
        vectors++; if (in0_ready !== 1'b0) begin miscompares++; $display("FAIL arst_in0_ready: got %b required 0", in0_ready); end
        vectors++; if (in1_ready !== 1'b0) begin miscompares++; $display("FAIL arst_in1_ready: got %b required 0", in1_ready); end
        vectors++; if (out_data !== 9'h000) begin miscompares++; $display("FAIL arst_out_data: got %h required 000", out_data); end
        @(posedge CLK); #1;
        _RESET = 1'b1;
        got_q.delete();
        out_ready = 1'b1;
        @(negedge CLK);
        vectors++; if (in0_ready !== 1'b1) begin miscompares++; $display("FAIL arst_in0_first: got %b required 1", in0_ready); end
        vectors++; if (in1_ready !== 1'b0) begin miscompares++; $display("FAIL arst_in1_waits: got %b required 0", in1_ready); end
        @(posedge CLK); #1;
        set_in(0, 1'b0, '0);
        @(negedge CLK);
        vectors++; if (in1_ready !== 1'b1) begin miscompares++; $display("FAIL arst_in1_next: got %b required 1", in1_ready); end
        @(posedge CLK); #1;
        set_in(1, 1'b0, '0);
        drain_and_compare("async_reset", exp, 2);
    endtask

    initial begin
        pend0 = 1'b0; pend1 = 1'b0;
        prev0 = '0;   prev1 = '0;
        test_reset();
        test_single_flit();
        test_wormhole();
        test_fairness();
        test_backpressure();
        test_lock_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
